icb_mem_responder: RTL and testbench

ICB_MEM_RESPONDER -- requirements
Module: icb_mem_responder

---
 rtl/icb_mem_responder.sv | 119 +++++++++++
 tb/tb_icb_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icb_mem_responder.sv
// ICB slave over a word-addressed byte-lane memory. A command is staged one edge, then
// enters an in-order response buffer; cmd_ready drops when staged + buffered reaches RSP_DEPTH.
module icb_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RSP_DEPTH   = 4
) (
    input  logic        nice_clk,
    input  logic        nice_rst_n,
    input  logic        nice_icb_cmd_valid,
    output logic        nice_icb_cmd_ready,
    input  logic [31:0] nice_icb_cmd_addr,
    input  logic        nice_icb_cmd_read,
    input  logic [31:0] nice_icb_cmd_wdata,
    input  logic [1:0]  nice_icb_cmd_size,
    output logic        nice_icb_rsp_valid,
    input  logic        nice_icb_rsp_ready,
    output logic [31:0] nice_icb_rsp_rdata,
    output logic        nice_icb_rsp_err,
    output logic [15:0] err_count
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          PTR_W     = $clog2(RSP_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      buf_rdata_q [RSP_DEPTH];
    logic             buf_err_q [RSP_DEPTH];

    logic             stg_vld_q, stg_vld_d;
    logic             stg_err_q;
    logic [31:0]      stg_rdata_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic [31:0]      offset;
    logic             in_range, misaligned, cmd_err, cmd_acc, pop;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wr_be;
    logic [CNT_W-1:0] occ;

    always_comb begin
        offset     = nice_icb_cmd_addr - ADDR_BASE;
        in_range   = (nice_icb_cmd_addr >= ADDR_BASE) && ({1'b0, offset} < WIN_BYTES);
        misaligned = ((nice_icb_cmd_size == 2'b01) && nice_icb_cmd_addr[0]) ||
                     ((nice_icb_cmd_size == 2'b10) && (nice_icb_cmd_addr[1:0] != 2'b00));
        cmd_err    = (nice_icb_cmd_size == 2'b11) || !in_range || misaligned;
        idx        = offset[IDX_W+1:2];
        case (nice_icb_cmd_size)
            2'b00:   wr_be = 4'b0001 << nice_icb_cmd_addr[1:0];
            2'b01:   wr_be = nice_icb_cmd_addr[1] ? 4'b1100 : 4'b0011;
            default: wr_be = 4'b1111;
        endcase
    end

    // Occupancy counts the staging slot too; ready is gated by reset so it reads 0 while held.
    assign occ                = cnt_q + CNT_W'(stg_vld_q);
    assign nice_icb_cmd_ready = nice_rst_n && (occ < CNT_W'(RSP_DEPTH));
    assign cmd_acc            = nice_icb_cmd_valid && nice_icb_cmd_ready;
    assign nice_icb_rsp_valid = (cnt_q != '0);
    assign pop                = nice_icb_rsp_valid && nice_icb_rsp_ready;
    assign nice_icb_rsp_rdata = nice_icb_rsp_valid ? buf_rdata_q[rd_ptr_q] : 32'h0;
    assign nice_icb_rsp_err   = nice_icb_rsp_valid ? buf_err_q[rd_ptr_q] : 1'b0;
    assign err_count          = err_cnt_q;

    always_comb begin
        stg_vld_d = cmd_acc;
        wr_ptr_d  = stg_vld_q ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d     = cnt_q + CNT_W'(stg_vld_q) - CNT_W'(pop);
        err_cnt_d = err_cnt_q;
        if (pop && nice_icb_rsp_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Memory and data storage carry no reset; occupancy and valid flags gate their use.
    always_ff @(posedge nice_clk) begin
        if (cmd_acc && !nice_icb_cmd_read && !cmd_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[idx][b*8 +: 8] <= nice_icb_cmd_wdata[b*8 +: 8];
                end
            end
        end
        if (cmd_acc) begin
            stg_rdata_q <= (nice_icb_cmd_read && !cmd_err) ? mem_q[idx] : 32'h0;
        end
        if (stg_vld_q) begin
            buf_rdata_q[wr_ptr_q] <= stg_rdata_q;
            buf_err_q[wr_ptr_q]   <= stg_err_q;
        end
    end

    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            stg_vld_q <= 1'b0;
            stg_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_cnt_q <= 16'h0;
        end else begin
            stg_vld_q <= stg_vld_d;
            if (cmd_acc) begin
                stg_err_q <= cmd_err;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_icb_mem_responder.sv
// Bench for icb_mem_responder: vector table streamed through a response scoreboard,
// plus backpressure, full-boundary and mid-flight reset sequences.
module tb_icb_mem_responder;

    logic        nice_clk = 1'b0;
    logic        nice_rst_n;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] err_count;

    always #5 nice_clk = ~nice_clk;

    icb_mem_responder dut (
        .nice_clk           (nice_clk),
        .nice_rst_n         (nice_rst_n),
        .nice_icb_cmd_valid (cmd_valid),
        .nice_icb_cmd_ready (cmd_ready),
        .nice_icb_cmd_addr  (cmd_addr),
        .nice_icb_cmd_read  (cmd_read),
        .nice_icb_cmd_wdata (cmd_wdata),
        .nice_icb_cmd_size  (cmd_size),
        .nice_icb_rsp_valid (rsp_valid),
        .nice_icb_rsp_ready (rsp_ready),
        .nice_icb_rsp_rdata (rsp_rdata),
        .nice_icb_rsp_err   (rsp_err),
        .err_count          (err_count)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        bit          lat;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  n_rsp    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    always @(posedge nice_clk) cyc++;

    // Responses are checked at the negedge before the edge that consumes them.
    always @(negedge nice_clk) begin
        if (nice_rst_n && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                // accepted at edge N, visible after N+1: observed two samples later
                if (mon_e.lat) check("latency", 32'(cyc - mon_e.acc), 32'd2);
            end
        end
    end

    task automatic issue(input vec_t v, input bit lat, output int waits);
        bit done = 1'b0;
        waits     = 0;
        cmd_valid = 1'b1;
        cmd_read  = v.rd;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_size  = v.size;
        while (!done && waits < 50) begin
            @(negedge nice_clk);
            if (cmd_ready) begin
                sb.push_back('{err: v.exp_err, rdata: v.exp_rdata, acc: cyc, lat: lat});
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge nice_clk);
            #1;
        end
        check("cmd_accept", {31'b0, done}, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge nice_clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge nice_clk);
    endtask

    vec_t vt[16];
    vec_t bp[6];
    int   w, stalls, k, rsp_base;

    initial begin
        vt[0]  = '{1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 32'h1000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{1'b0, 32'h1000_0000, 32'h1122_3344, 2'b10, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h1000_0002, 32'h00AA_0000, 2'b00, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 32'h1000_0000, 32'h0,         2'b10, 1'b0, 32'h11AA_3344};
        vt[5]  = '{1'b1, 32'h0FFF_FFFC, 32'h0,         2'b10, 1'b1, 32'h0};
        vt[6]  = '{1'b1, 32'h1000_0002, 32'h0,         2'b10, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 32'h1000_0000, 32'h0,         2'b11, 1'b1, 32'h0};
        vt[8]  = '{1'b1, 32'h1000_0000, 32'h0,         2'b00, 1'b0, 32'h11AA_3344};
        vt[9]  = '{1'b0, 32'h1000_0002, 32'h5566_0000, 2'b01, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h1000_0001, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h0};
        vt[11] = '{1'b1, 32'h1000_0000, 32'h0,         2'b10, 1'b0, 32'h5566_3344};
        vt[12] = '{1'b0, 32'h1000_0FFC, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0};
        vt[13] = '{1'b1, 32'h1000_0FFC, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D};
        vt[14] = '{1'b0, 32'h1000_1000, 32'h1234_5678, 2'b10, 1'b1, 32'h0};
        vt[15] = '{1'b1, 32'h1000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF};
        for (int i = 0; i < 6; i++) begin
            bp[i] = '{1'b1, 32'h1000_0010, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF};
        end
        bp[1].addr = 32'h1000_0000; bp[1].exp_rdata = 32'h5566_3344;
        bp[2].addr = 32'h1000_0FFC; bp[2].exp_rdata = 32'hCAFE_F00D;

        nice_rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_size = '0;
        rsp_ready = 1'b0;
        #1 nice_rst_n = 1'b0;
        repeat (3) @(posedge nice_clk);
        #1;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_err_count", {16'b0, err_count}, 32'd0);
        #2 nice_rst_n = 1'b1;
        #1 check("ready_after_release", {31'b0, cmd_ready}, 32'd1);
        @(posedge nice_clk);
        #1;

        // Streaming the vector table: one accept per cycle, fixed latency.
        rsp_ready = 1'b1;
        stalls = 0;
        foreach (vt[i]) begin
            issue(vt[i], 1'b1, w);
            stalls += w;
        end
        cmd_valid = 1'b0;
        drain();
        check("stream_stalls", 32'(stalls), 32'd0);
        check("err_count_5", {16'b0, err_count}, 32'd5);

        // Backpressure: six reads offered, four fit, then release.
        @(posedge nice_clk);
        #1 rsp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (k < 6);
            if (k < 6) begin
                cmd_read = bp[k].rd; cmd_addr = bp[k].addr; cmd_size = bp[k].size;
            end
            @(negedge nice_clk);
            if (cmd_valid && cmd_ready) begin
                sb.push_back('{err: bp[k].exp_err, rdata: bp[k].exp_rdata, acc: cyc, lat: 1'b0});
                k++;
            end
            @(posedge nice_clk);
            #1;
        end
        cmd_valid = 1'b0;
        @(negedge nice_clk);
        check("bp_accepted", 32'(k), 32'd4);
        check("bp_full_ready", {31'b0, cmd_ready}, 32'd0);
        check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
        check("bp_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
        @(posedge nice_clk);
        #1 rsp_ready = 1'b1;
        @(negedge nice_clk);
        check("no_passthrough", {31'b0, cmd_ready}, 32'd0);
        @(negedge nice_clk);
        check("ready_after_pop", {31'b0, cmd_ready}, 32'd1);
        drain();

        // Reset with three responses pending.
        @(posedge nice_clk);
        #1 rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(bp[i], 1'b0, w);
        cmd_valid = 1'b0;
        repeat (2) @(negedge nice_clk);
        check("pending_before_rst", {31'b0, rsp_valid}, 32'd1);
        #2 nice_rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("midrst_err_count", {16'b0, err_count}, 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        sb.delete();
        rsp_ready = 1'b1;
        rsp_base = n_rsp;
        repeat (2) @(posedge nice_clk);
        #3 nice_rst_n = 1'b1;
        #1 check("ready_after_midrst", {31'b0, cmd_ready}, 32'd1);
        repeat (6) @(negedge nice_clk);
        check("no_stale_rsp", 32'(n_rsp - rsp_base), 32'd0);

        // Memory survives reset; error counting restarts from zero.
        @(posedge nice_clk);
        #1;
        issue(vt[15], 1'b1, w);
        issue(vt[7], 1'b1, w);
        cmd_valid = 1'b0;
        drain();
        check("err_count_after_rst", {16'b0, err_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
